// File: rtl/rename_stage_if.sv
// rename_stage_if: decode/freelist/dispatch bundle of the 2-wide rename stage.
//   slave modport  : the rename stage (decode + freelist in, dispatch + alloc out)
//   master modport : the surrounding pipeline / testbench
//   in_*           : decode group (valid/ready, slot valids, src/dst aregs, branch tags)
//   fl_*, alloc_*  : freelist offer and consumption
//   branch_shootdown/shootdown_tag : mispredict restore request
//   out_*          : registered renamed group (valid/ready)
//   perf_* (only with RENAME_PERF_CNT_EN) : stall and renamed-uop counters
interface rename_stage_if #(
  parameter int NUM_AREGS         = 32,
  parameter int NUM_PREGS         = 64,
  parameter int MAX_PREDICT_DEPTH = 4
);
  localparam int AW = $clog2(NUM_AREGS);
  localparam int PW = $clog2(NUM_PREGS);
  localparam int TW = $clog2(MAX_PREDICT_DEPTH) + 1;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_slot_v;
  logic [1:0][AW-1:0]  in_src1;
  logic [1:0][AW-1:0]  in_src2;
  logic [1:0][AW-1:0]  in_dst;
  logic [1:0]          in_has_dst;
  logic [1:0][TW-1:0]  in_branch_tag;
  logic [PW-1:0]       fl_preg1;
  logic [PW-1:0]       fl_preg2;
  logic [PW:0]         fl_num_free;
  logic [1:0]          alloc_num;
  logic [TW-1:0]       alloc_tag1;
  logic [TW-1:0]       alloc_tag2;
  logic                branch_shootdown;
  logic [TW-1:0]       shootdown_tag;
  logic                out_valid;
  logic                out_ready;
  logic [1:0]          out_slot_v;
  logic [1:0][PW-1:0]  out_psrc1;
  logic [1:0][PW-1:0]  out_psrc2;
  logic [1:0][PW-1:0]  out_pdst;
  logic [1:0][PW-1:0]  out_old_pdst;
  logic [1:0][TW-1:0]  out_branch_tag;
`ifdef RENAME_PERF_CNT_EN
  logic [31:0]         perf_stall_fl;
  logic [31:0]         perf_renamed;
`endif
  modport slave (
    input  in_valid, in_slot_v, in_src1, in_src2, in_dst, in_has_dst, in_branch_tag,
    input  fl_preg1, fl_preg2, fl_num_free, branch_shootdown, shootdown_tag, out_ready,
    output in_ready, alloc_num, alloc_tag1, alloc_tag2,
    output out_valid, out_slot_v, out_psrc1, out_psrc2, out_pdst, out_old_pdst, out_branch_tag
`ifdef RENAME_PERF_CNT_EN
    , output perf_stall_fl, perf_renamed
`endif
  );
  modport master (
    output in_valid, in_slot_v, in_src1, in_src2, in_dst, in_has_dst, in_branch_tag,
    output fl_preg1, fl_preg2, fl_num_free, branch_shootdown, shootdown_tag, out_ready,
    input  in_ready, alloc_num, alloc_tag1, alloc_tag2,
    input  out_valid, out_slot_v, out_psrc1, out_psrc2, out_pdst, out_old_pdst, out_branch_tag
`ifdef RENAME_PERF_CNT_EN
    , input perf_stall_fl, perf_renamed
`endif
  );
endinterface

// File: rtl/rename_stage.sv
// rename_stage: 2-wide register rename with RAT, per-branch RAT checkpoints and a 1-deep output stage.
//   clk, reset : clock; synchronous active-high reset
//   io (slave) : decode input group, freelist offer/alloc, shootdown, registered renamed output
//   Optional RENAME_PERF_CNT_EN adds saturating counters io.perf_stall_fl and io.perf_renamed.
module rename_stage #(
  parameter int NUM_AREGS         = 32,
  parameter int NUM_PREGS         = 64,
  parameter int MAX_PREDICT_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  rename_stage_if.slave io
);
  localparam int AW = $clog2(NUM_AREGS);
  localparam int PW = $clog2(NUM_PREGS);
  localparam int TW = $clog2(MAX_PREDICT_DEPTH) + 1;
  localparam int CW = (MAX_PREDICT_DEPTH > 1) ? $clog2(MAX_PREDICT_DEPTH) : 1;
  logic [PW-1:0] rat     [NUM_AREGS];
  logic [PW-1:0] rat_mid [NUM_AREGS];
  logic [PW-1:0] rat_fin [NUM_AREGS];
  logic [PW-1:0] ckpt    [MAX_PREDICT_DEPTH][NUM_AREGS];
  logic [1:0]          wr;
  logic [1:0]          need;
  logic                acc;
  logic [1:0][PW-1:0]  psrc1, psrc2, pdst, old_pdst;
  logic [1:0]          ck_en;
  logic [1:0][CW-1:0]  ck_idx;
  logic                sd_ok;
  logic [CW-1:0]       sd_idx;
  function automatic logic tag_ok(logic [TW-1:0] t);
    return t != '0 && 32'(t) <= MAX_PREDICT_DEPTH;
  endfunction
  // a slot allocates only when it writes a real (non-zero) architectural register
  assign wr[0] = io.in_slot_v[0] && io.in_has_dst[0] && io.in_dst[0] != '0;
  assign wr[1] = io.in_slot_v[1] && io.in_has_dst[1] && io.in_dst[1] != '0;
  assign need  = {1'b0, wr[0]} + {1'b0, wr[1]};
  assign io.in_ready = !reset && !io.branch_shootdown && (!io.out_valid || io.out_ready) &&
                       io.fl_num_free >= (PW+1)'(need);
  assign acc = io.in_valid && io.in_ready;
  assign io.alloc_num  = acc ? need : 2'd0;
  assign io.alloc_tag1 = !acc ? '0 : wr[0] ? io.in_branch_tag[0] : wr[1] ? io.in_branch_tag[1] : '0;
  assign io.alloc_tag2 = (acc && wr[0] && wr[1]) ? io.in_branch_tag[1] : '0;
  // slot1 takes the second offered preg only when slot0 already consumed the first
  assign pdst[0] = wr[0] ? io.fl_preg1 : '0;
  assign pdst[1] = !wr[1] ? '0 : wr[0] ? io.fl_preg2 : io.fl_preg1;
  assign psrc1[0] = (io.in_src1[0] == '0) ? '0 : rat[io.in_src1[0]];
  assign psrc2[0] = (io.in_src2[0] == '0) ? '0 : rat[io.in_src2[0]];
  // intra-group dependency: slot1 sources see slot0's fresh destination
  assign psrc1[1] = (io.in_src1[1] == '0) ? '0 :
                    (wr[0] && io.in_src1[1] == io.in_dst[0]) ? pdst[0] : rat[io.in_src1[1]];
  assign psrc2[1] = (io.in_src2[1] == '0) ? '0 :
                    (wr[0] && io.in_src2[1] == io.in_dst[0]) ? pdst[0] : rat[io.in_src2[1]];
  assign old_pdst[0] = wr[0] ? rat[io.in_dst[0]] : '0;
  assign old_pdst[1] = !wr[1] ? '0 :
                       (wr[0] && io.in_dst[1] == io.in_dst[0]) ? pdst[0] : rat[io.in_dst[1]];
  assign ck_en[0]  = io.in_slot_v[0] && tag_ok(io.in_branch_tag[0]);
  assign ck_en[1]  = io.in_slot_v[1] && tag_ok(io.in_branch_tag[1]);
  assign ck_idx[0] = CW'(io.in_branch_tag[0] - 1'b1);
  assign ck_idx[1] = CW'(io.in_branch_tag[1] - 1'b1);
  assign sd_ok     = tag_ok(io.shootdown_tag);
  assign sd_idx    = CW'(io.shootdown_tag - 1'b1);
  // RAT after slot0 only (slot0 branch snapshot) and after both slots (final/slot1 snapshot)
  always_comb begin
    rat_mid = rat;
    if (wr[0]) rat_mid[io.in_dst[0]] = pdst[0];
    rat_fin = rat_mid;
    if (wr[1]) rat_fin[io.in_dst[1]] = pdst[1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_AREGS; i++) begin
        rat[i] <= PW'(i);
        for (int j = 0; j < MAX_PREDICT_DEPTH; j++) ckpt[j][i] <= PW'(i);
      end
      io.out_valid      <= 1'b0;
      io.out_slot_v     <= '0;
      io.out_psrc1      <= '0;
      io.out_psrc2      <= '0;
      io.out_pdst       <= '0;
      io.out_old_pdst   <= '0;
      io.out_branch_tag <= '0;
    end else if (io.branch_shootdown) begin
      if (sd_ok)
        for (int i = 0; i < NUM_AREGS; i++) rat[i] <= ckpt[sd_idx][i];
      io.out_valid <= 1'b0;
    end else if (acc) begin
      for (int i = 0; i < NUM_AREGS; i++) begin
        rat[i] <= rat_fin[i];
        if (ck_en[0]) ckpt[ck_idx[0]][i] <= rat_mid[i];
        if (ck_en[1]) ckpt[ck_idx[1]][i] <= rat_fin[i];
      end
      io.out_valid      <= 1'b1;
      io.out_slot_v     <= io.in_slot_v;
      io.out_psrc1      <= psrc1;
      io.out_psrc2      <= psrc2;
      io.out_pdst       <= pdst;
      io.out_old_pdst   <= old_pdst;
      io.out_branch_tag <= io.in_branch_tag;
    end else if (io.out_ready) begin
      io.out_valid <= 1'b0;
    end
  end
`ifdef RENAME_PERF_CNT_EN
  logic [1:0] n_uops;
  assign n_uops = {1'b0, io.in_slot_v[0]} + {1'b0, io.in_slot_v[1]};
  always_ff @(posedge clk) begin
    if (reset) begin
      io.perf_stall_fl <= '0;
      io.perf_renamed  <= '0;
    end else begin
      if (io.in_valid && io.fl_num_free < (PW+1)'(need) && !io.branch_shootdown && io.perf_stall_fl != '1)
        io.perf_stall_fl <= io.perf_stall_fl + 32'd1;
      if (acc)
        io.perf_renamed <= (io.perf_renamed > 32'hFFFF_FFFF - 32'(n_uops)) ? '1 : io.perf_renamed + 32'(n_uops);
    end
  end
`endif
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: directed + randomized check of rename_stage against a sequential rename model.
module tb_rename_stage;
  localparam int NA = 32;
  localparam int NP = 64;
  localparam int MD = 4;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  rename_stage_if #(.NUM_AREGS(NA), .NUM_PREGS(NP), .MAX_PREDICT_DEPTH(MD)) io ();
  rename_stage #(.NUM_AREGS(NA), .NUM_PREGS(NP), .MAX_PREDICT_DEPTH(MD)) dut (
    .clk(clk), .reset(reset), .io(io)
  );
  int n_cmp = 0;
  int n_err = 0;
  int rat_m [NA];
  int ck_m  [MD][NA];
  bit       e_v;
  bit [1:0] e_sv;
  int e_ps1[2], e_ps2[2], e_pd[2], e_od[2], e_bt[2];
  int a_seen, r_seen;
  task automatic chk(string t, logic [63:0] o, logic [63:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", t, o, e);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      rat_m[i] = i;
      for (int j = 0; j < MD; j++) ck_m[j][i] = i;
    end
    e_v = 0;
  endtask
  task automatic idle();
    io.in_valid = 0; io.in_slot_v = '0; io.in_src1 = '0; io.in_src2 = '0;
    io.in_dst = '0; io.in_has_dst = '0; io.in_branch_tag = '0;
    io.branch_shootdown = 0; io.shootdown_tag = '0;
  endtask
  task automatic uop(int s, int a, int b, int d, bit hd, int t);
    io.in_valid = 1; io.in_slot_v[s] = 1'b1;
    io.in_src1[s] = 5'(a); io.in_src2[s] = 5'(b); io.in_dst[s] = 5'(d);
    io.in_has_dst[s] = hd; io.in_branch_tag[s] = 3'(t);
  endtask
  // one clock: check at negedge, advance model at posedge, return 1 time unit after the edge
  task automatic cycle();
    bit w[2];
    int need, k, t1, t2, tg, off[2];
    bit rdy, acc;
    @(negedge clk);
    for (int s = 0; s < 2; s++) w[s] = io.in_slot_v[s] && io.in_has_dst[s] && io.in_dst[s] != 0;
    need = int'(w[0]) + int'(w[1]);
    rdy = !reset && !io.branch_shootdown && (!e_v || io.out_ready) && int'(io.fl_num_free) >= need;
    acc = io.in_valid && rdy;
    t1 = 0; t2 = 0; k = 0;
    if (acc)
      for (int s = 0; s < 2; s++)
        if (w[s]) begin
          if (k == 0) t1 = int'(io.in_branch_tag[s]); else t2 = int'(io.in_branch_tag[s]);
          k++;
        end
    chk("in_ready", io.in_ready, rdy);
    chk("alloc_num", io.alloc_num, acc ? need : 0);
    chk("alloc_tag1", io.alloc_tag1, t1);
    chk("alloc_tag2", io.alloc_tag2, t2);
    chk("out_valid", io.out_valid, e_v);
    if (e_v) begin
      chk("out_slot_v", io.out_slot_v, e_sv);
      for (int s = 0; s < 2; s++)
        if (e_sv[s]) begin
          chk($sformatf("psrc1[%0d]", s), io.out_psrc1[s], e_ps1[s]);
          chk($sformatf("psrc2[%0d]", s), io.out_psrc2[s], e_ps2[s]);
          chk($sformatf("pdst[%0d]", s), io.out_pdst[s], e_pd[s]);
          chk($sformatf("old_pdst[%0d]", s), io.out_old_pdst[s], e_od[s]);
          chk($sformatf("btag[%0d]", s), io.out_branch_tag[s], e_bt[s]);
        end
    end
    a_seen = int'(io.alloc_num);
    r_seen = int'(io.in_ready);
    @(posedge clk);
    if (reset) model_reset();
    else if (io.branch_shootdown) begin
      tg = int'(io.shootdown_tag);
      if (tg >= 1 && tg <= MD) for (int i = 0; i < NA; i++) rat_m[i] = ck_m[tg-1][i];
      e_v = 0;
    end else if (acc) begin
      off[0] = int'(io.fl_preg1); off[1] = int'(io.fl_preg2); k = 0;
      e_v = 1; e_sv = io.in_slot_v;
      for (int s = 0; s < 2; s++)
        if (io.in_slot_v[s]) begin
          e_ps1[s] = (io.in_src1[s] == 0) ? 0 : rat_m[io.in_src1[s]];
          e_ps2[s] = (io.in_src2[s] == 0) ? 0 : rat_m[io.in_src2[s]];
          if (w[s]) begin
            e_pd[s] = off[k]; k++;
            e_od[s] = rat_m[io.in_dst[s]];
            rat_m[io.in_dst[s]] = e_pd[s];
          end else begin
            e_pd[s] = 0; e_od[s] = 0;
          end
          e_bt[s] = int'(io.in_branch_tag[s]);
          tg = e_bt[s];
          if (tg >= 1 && tg <= MD) for (int i = 0; i < NA; i++) ck_m[tg-1][i] = rat_m[i];
        end
    end else if (io.out_ready) e_v = 0;
    #1;
  endtask
  initial begin
    reset = 1; idle();
    io.out_ready = 1; io.fl_preg1 = 40; io.fl_preg2 = 41; io.fl_num_free = 10;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cycle();
    reset = 0;
    // r1 <= r2 + r3
    idle(); uop(0, 2, 3, 1, 1, 0); cycle();
    chk("t1_alloc", a_seen, 1);
    chk("t1_psrc1", io.out_psrc1[0], 2);
    chk("t1_psrc2", io.out_psrc2[0], 3);
    chk("t1_pdst", io.out_pdst[0], 40);
    chk("t1_old", io.out_old_pdst[0], 1);
    // r5 <= r0+r0 ; r6 <= r5+r5 (bypass)
    idle(); uop(0, 0, 0, 5, 1, 0); uop(1, 5, 5, 6, 1, 0); cycle();
    chk("t2_alloc", a_seen, 2);
    chk("t2_psrc1", io.out_psrc1[1], 40);
    chk("t2_psrc2", io.out_psrc2[1], 40);
    chk("t2_pdst1", io.out_pdst[1], 41);
    idle(); uop(0, 5, 6, 0, 0, 0); cycle();
    chk("t2_rat5", io.out_psrc1[0], 40);
    chk("t2_rat6", io.out_psrc2[0], 41);
    // both slots write r7
    idle(); uop(0, 1, 2, 7, 1, 0); uop(1, 3, 4, 7, 1, 0); cycle();
    chk("t3_old0", io.out_old_pdst[0], 7);
    chk("t3_old1", io.out_old_pdst[1], 40);
    idle(); uop(0, 7, 0, 0, 0, 0); cycle();
    chk("t3_rat7", io.out_psrc1[0], 41);
    // branch tag1 in slot0, r4 <= .. in slot1, then shootdown tag1
    idle(); io.fl_preg1 = 42; io.fl_preg2 = 43;
    uop(0, 1, 1, 0, 0, 1); uop(1, 2, 3, 4, 1, 0); cycle();
    chk("t4_pdst1", io.out_pdst[1], 42);
    idle(); uop(0, 4, 0, 4, 1, 0); io.branch_shootdown = 1; io.shootdown_tag = 1; cycle();
    chk("t4_ready", r_seen, 0);
    chk("t4_alloc", a_seen, 0);
    chk("t4_outv", io.out_valid, 0);
    idle(); uop(0, 4, 0, 0, 0, 0); cycle();
    chk("t4_rat4", io.out_psrc1[0], 4);
    // freelist short, then stall held by out_ready=0
    idle(); io.fl_num_free = 1; uop(0, 1, 1, 8, 1, 0); uop(1, 1, 1, 9, 1, 0); cycle();
    chk("t5_ready", r_seen, 0);
    chk("t5_alloc", a_seen, 0);
    io.fl_num_free = 10; cycle();
    io.out_ready = 0; idle(); uop(0, 2, 2, 3, 1, 0); cycle(); cycle();
    chk("t5_hold_v", io.out_valid, 1);
    chk("t5_hold_p0", io.out_pdst[0], 42);
    chk("t5_hold_p1", io.out_pdst[1], 43);
    io.out_ready = 1; cycle();
    // reset mid-operation beats shootdown and accept
    reset = 1; io.branch_shootdown = 1; io.shootdown_tag = 1; cycle();
    reset = 0; idle(); uop(0, 1, 7, 0, 0, 0); cycle();
    chk("t6_rat1", io.out_psrc1[0], 1);
    chk("t6_rat7", io.out_psrc2[0], 7);
    // randomized traffic
    repeat (800) begin
      idle();
      reset = ($urandom_range(0, 99) == 0);
      io.out_ready = ($urandom_range(0, 9) < 7);
      io.fl_preg1 = 6'($urandom_range(32, 63));
      io.fl_preg2 = 6'($urandom_range(32, 63));
      io.fl_num_free = 7'($urandom_range(0, 4));
      io.branch_shootdown = ($urandom_range(0, 19) == 0);
      io.shootdown_tag = 3'($urandom_range(0, MD));
      if ($urandom_range(0, 9) < 7)
        for (int s = 0; s < int'($urandom_range(1, 2)); s++)
          uop(s, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 3) != 0, ($urandom_range(0, 3) == 0) ? $urandom_range(1, MD) : 0);
      cycle();
    end
    reset = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
